// File: rtl/iomem_initiator_if.sv
// Command, response and iomem bus signals of the iomem initiator, grouped for port connection.
// master is the initiator side; slave is the agent/peripheral side seen from outside.
interface iomem_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_wstrb;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_write;

    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;

    modport master (
        input  cmd_valid, cmd_wstrb, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_write,
        input  rsp_ready,
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        output cmd_valid, cmd_wstrb, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_write,
        output rsp_ready,
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_initiator.sv
// Single-outstanding iomem bus master: bus request the cycle after accept, response the cycle after ready/timeout.
// Backpressure: cmd_ready stays low from accept until the response is taken with rsp_ready.
module iomem_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic              ck,
    input  logic              rst,
    iomem_initiator_if.master bus,
    output logic              busy
);
    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;

    logic          iomem_valid_q, iomem_valid_d;
    logic [3:0]    iomem_wstrb_q, iomem_wstrb_d;
    logic [31:0]   iomem_addr_q,  iomem_addr_d;
    logic [31:0]   iomem_wdata_q, iomem_wdata_d;
    logic          rsp_valid_q,   rsp_valid_d;
    logic [31:0]   rsp_rdata_q,   rsp_rdata_d;
    logic          rsp_err_q,     rsp_err_d;
    logic          rsp_write_q,   rsp_write_d;
    logic [CW-1:0] cnt_q,         cnt_d;

    logic accept;
    logic bus_done;
    logic timeout_hit;

    assign accept   = (state_q == IDLE) && bus.cmd_valid;
    assign bus_done = (state_q == BUS) && bus.iomem_ready;
    // A peripheral ready in the expiry cycle takes priority over the abort.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == BUS) && !bus.iomem_ready && (cnt_q == LAST);

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUS;
            BUS:     if (bus_done || timeout_hit) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iomem_valid_d = iomem_valid_q;
        iomem_wstrb_d = iomem_wstrb_q;
        iomem_addr_d  = iomem_addr_q;
        iomem_wdata_d = iomem_wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_write_d   = rsp_write_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    iomem_valid_d = 1'b1;
                    iomem_wstrb_d = bus.cmd_wstrb;
                    iomem_addr_d  = bus.cmd_addr;
                    iomem_wdata_d = bus.cmd_wdata;
                    cnt_d         = '0;
                end
            end
            BUS: begin
                if (bus_done || timeout_hit) begin
                    iomem_valid_d = 1'b0;
                    iomem_wstrb_d = '0;
                    iomem_addr_d  = '0;
                    iomem_wdata_d = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = timeout_hit;
                    rsp_write_d   = (iomem_wstrb_q != 4'd0);
                    rsp_rdata_d   = (bus_done && (iomem_wstrb_q == 4'd0)) ? bus.iomem_rdata : 32'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            iomem_valid_q <= 1'b0;
            iomem_wstrb_q <= '0;
            iomem_addr_q  <= '0;
            iomem_wdata_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_write_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            iomem_valid_q <= iomem_valid_d;
            iomem_wstrb_q <= iomem_wstrb_d;
            iomem_addr_q  <= iomem_addr_d;
            iomem_wdata_q <= iomem_wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_write_q   <= rsp_write_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign bus.iomem_valid = iomem_valid_q;
    assign bus.iomem_wstrb = iomem_wstrb_q;
    assign bus.iomem_addr  = iomem_addr_q;
    assign bus.iomem_wdata = iomem_wdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_write   = rsp_write_q;
endmodule

// File: tb/tb_iomem_initiator.sv
// Scoreboard bench for iomem_initiator: directed plan items followed by random traffic,
// with a behavioural peripheral and a response monitor working from queues.
module tb_iomem_initiator;
    localparam int TO = 8;

    logic ck = 1'b0;
    logic rst = 1'b1;
    logic busy;

    iomem_initiator_if bus();

    iomem_initiator #(.TIMEOUT(TO)) dut (
        .ck   (ck),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        wr;
    } rsp_t;

    typedef struct packed {
        logic [3:0]  ws;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        int          vcnt;
    } breq_t;

    rsp_t        exp_q[$];
    breq_t       bq[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] pmem      [logic [31:0]];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_rsp_edge = -10;
    int hold_rsp = 0;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: wait bound expired or unexpected event (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A0F_C3E1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] prd(input logic [31:0] a);
        return pmem.exists(a) ? pmem[a] : dflt(a);
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"},   32'(bus.cmd_ready),   32'd1);
        chk({tag, "_busy"},        32'(busy),            32'd0);
        chk({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'd0);
        chk({tag, "_rsp_err"},     32'(bus.rsp_err),     32'd0);
        chk({tag, "_rsp_write"},   32'(bus.rsp_write),   32'd0);
        chk({tag, "_rsp_rdata"},   bus.rsp_rdata,        32'd0);
        chk({tag, "_iomem_valid"}, 32'(bus.iomem_valid), 32'd0);
        chk({tag, "_iomem_wstrb"}, 32'(bus.iomem_wstrb), 32'd0);
        chk({tag, "_iomem_addr"},  bus.iomem_addr,       32'd0);
        chk({tag, "_iomem_wdata"}, bus.iomem_wdata,      32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] ws, input logic [31:0] a, input logic [31:0] d,
                         input int lat, input bit abort);
        int    n;
        rsp_t  e;
        breq_t b;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_wstrb = ws;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (!bus.cmd_ready) begin
            @(negedge ck);
            n++;
            if (n > 300) begin
                fail_now("cmd_accept_wait");
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        if (n > 0) chk("accept_after_rsp", 32'(cyc + 1), 32'(last_rsp_edge + 1));
        if (!abort) begin
            if (lat > TO) begin
                e = '{32'd0, 1'b1, (ws != 4'd0)};
            end else if (ws != 4'd0) begin
                e = '{32'd0, 1'b0, 1'b1};
                model_mem[a] = merge(mrd(a), d, ws);
            end else begin
                e = '{mrd(a), 1'b0, 1'b0};
            end
            exp_q.push_back(e);
        end
        b = '{ws, a, d, lat, abort ? 3 : ((lat > TO) ? TO : lat)};
        bq.push_back(b);
        @(negedge ck);
        bus.cmd_valid = 1'b0;
        bus.cmd_wstrb = 4'($urandom);
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy || exp_q.size() != 0) begin
            @(negedge ck);
            n++;
            if (n > 300) begin
                fail_now("idle_wait");
                return;
            end
        end
    endtask

    // Peripheral: answers after the latency carried with each request, pulses stray readies otherwise.
    initial begin : periph
        breq_t b;
        int    i;
        bus.iomem_ready = 1'b0;
        bus.iomem_rdata = '0;
        forever begin
            @(negedge ck);
            if (!bus.iomem_valid) begin
                bus.iomem_ready = ($urandom_range(0, 3) == 0);
                bus.iomem_rdata = $urandom;
            end else if (bq.size() == 0) begin
                fail_now("bus_unexpected");
                bus.iomem_ready = 1'b0;
            end else begin
                b = bq.pop_front();
                i = 1;
                forever begin
                    chk("bus_wstrb", 32'(bus.iomem_wstrb), 32'(b.ws));
                    chk("bus_addr", bus.iomem_addr, b.a);
                    chk("bus_wdata", bus.iomem_wdata, b.d);
                    chk("cmd_ready_in_bus", 32'(bus.cmd_ready), 32'd0);
                    chk("busy_in_bus", 32'(busy), 32'd1);
                    if (i == b.lat) begin
                        bus.iomem_ready = 1'b1;
                        if (b.ws != 4'd0) begin
                            pmem[b.a] = merge(prd(b.a), b.d, b.ws);
                            bus.iomem_rdata = $urandom;
                        end else begin
                            bus.iomem_rdata = prd(b.a);
                        end
                    end else begin
                        bus.iomem_ready = 1'b0;
                        bus.iomem_rdata = $urandom;
                    end
                    @(negedge ck);
                    if (!bus.iomem_valid) break;
                    i++;
                    if (i > 40) begin
                        fail_now("bus_stuck");
                        break;
                    end
                end
                bus.iomem_ready = 1'b0;
                chk("valid_cycles", 32'(i), 32'(b.vcnt));
                chk("bus_idle_wstrb", 32'(bus.iomem_wstrb), 32'd0);
                chk("bus_idle_addr", bus.iomem_addr, 32'd0);
                chk("bus_idle_wdata", bus.iomem_wdata, 32'd0);
            end
        end
    end

    // Monitor: pops the expected response when one appears, re-checks it every held cycle.
    initial begin : monitor
        rsp_t cur;
        bit   have;
        have = 1'b0;
        cur = '0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge ck);
            if (bus.rsp_valid) begin
                if (!have) begin
                    if (exp_q.size() == 0) fail_now("rsp_unexpected");
                    else cur = exp_q.pop_front();
                    have = 1'b1;
                end
                chk("rsp_rdata", bus.rsp_rdata, cur.rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
                chk("rsp_write", 32'(bus.rsp_write), 32'(cur.wr));
                chk("cmd_ready_in_resp", 32'(bus.cmd_ready), 32'd0);
                chk("iomem_valid_in_resp", 32'(bus.iomem_valid), 32'd0);
                if (hold_rsp > 0) begin
                    bus.rsp_ready = 1'b0;
                    hold_rsp--;
                end else begin
                    bus.rsp_ready = ($urandom_range(0, 2) != 0);
                end
                if (bus.rsp_ready) last_rsp_edge = cyc + 1;
            end else begin
                have = 1'b0;
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [3:0] ws;
        int         lat;
        bus.cmd_valid = 1'b0;
        bus.cmd_wstrb = '0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge ck);
        check_reset("reset");
        rst = 1'b0;

        pmem[32'h6000_0004]      = 32'h1234_5678;
        model_mem[32'h6000_0004] = 32'h1234_5678;

        issue(4'hF, 32'h6000_0000, 32'hA5A5_A5A5, 3, 1'b0);
        issue(4'h0, 32'h6000_0004, 32'h0, 1, 1'b0);
        issue(4'h0, 32'h7000_0000, 32'h0, 20, 1'b0);
        issue(4'h0, 32'h7000_0000, 32'h0, TO, 1'b0);

        wait_idle();
        hold_rsp = 5;
        issue(4'hF, 32'h6000_0008, 32'hC0FF_EE11, 1, 1'b0);
        issue(4'h0, 32'h6000_0008, 32'h0, 2, 1'b0);

        wait_idle();
        issue(4'h3, 32'h6000_000C, 32'hDEAD_BEEF, 30, 1'b1);
        @(negedge ck);
        @(negedge ck);
        rst = 1'b1;
        @(negedge ck);
        check_reset("mid_bus_reset");
        rst = 1'b0;
        issue(4'h0, 32'h6000_000C, 32'h0, 2, 1'b0);

        for (int k = 0; k < 60; k++) begin
            ws  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            lat = ($urandom_range(0, 5) == 0) ? $urandom_range(TO + 1, TO + 4) : $urandom_range(1, TO);
            issue(ws, 32'h6000_0000 + 32'(4 * $urandom_range(0, 7)), $urandom, lat, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge ck);
        end

        wait_idle();
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("bus_q_drained", 32'(bq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
